// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN activation path.
// Holds the activation-LUT FSM state type and the default table geometry.
// The activation stage uses the same geometry, so both sides agree on
// the table depth and entry width.
package cnn_pkg;

    // Default LUT address width. The table depth is 2**ACT_MEM_WIDTH.
    localparam int ACT_MEM_WIDTH     = 5;
    // Default LUT entry width. Entries are signed.
    localparam int ACT_IP_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } act_lut_state_t;

endpackage

// File: rtl/act_lut_ram.sv
// Activation LUT storage.
// Simple dual-port memory with one synchronous write port and one
// registered read port. The read is read-before-write: a read of the
// address being written in the same cycle returns the old contents.
// Ports:
//   clk      - single clock, posedge
//   rst      - synchronous active-high; clears only the read register
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every cycle
//   rd_data  - registered mem[rd_addr]
module act_lut_ram
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH = ACT_MEM_WIDTH,
    parameter int DATA_WIDTH = ACT_IP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Table contents survive reset so a loaded table stays usable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Both blocks see the pre-edge memory, which gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/act_lut_writer.sv
// Activation LUT loader and owner.
// Takes table entries over a valid/ready stream and writes them into
// the LUT at addresses 0, 1, 2, ... After the last address is written,
// the table is frozen and flagged ready for the activation stage.
// Reads are served in every state with one cycle of latency.
// Ports:
//   clk       - single clock, posedge
//   rst       - synchronous active-high reset
//   start     - one-cycle request to (re)load the table from address 0
//   wr_valid  - wr_data holds a valid entry
//   wr_data   - signed table entry
//   wr_ready  - entry accepted this cycle (registered, LOAD state)
//   rd_addr   - lookup address
//   rd_data   - registered mem[rd_addr]
//   lut_ready - table fully loaded
//   done      - one-cycle pulse after the final entry is written
//   wr_count  - entries written in the current load
module act_lut_writer
    import cnn_pkg::*;
#(
    parameter int MEM_WIDTH     = ACT_MEM_WIDTH,
    parameter int IP_DATA_WIDTH = ACT_IP_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     wr_valid,
    input  logic [IP_DATA_WIDTH-1:0] wr_data,
    output logic                     wr_ready,
    input  logic [MEM_WIDTH-1:0]     rd_addr,
    output logic [IP_DATA_WIDTH-1:0] rd_data,
    output logic                     lut_ready,
    output logic                     done,
    output logic [MEM_WIDTH:0]       wr_count
);

    localparam logic [MEM_WIDTH:0] LAST_ADDR = (MEM_WIDTH+1)'((1 << MEM_WIDTH) - 1);

    act_lut_state_t state;
    logic           beat;
    logic           last_beat;

    // wr_ready is high only in LOAD, so a beat implies LOAD.
    // Gating with rst keeps a reset cycle from writing the table.
    assign beat      = wr_valid && wr_ready && !rst;
    assign last_beat = beat && (wr_count == LAST_ADDR);

    act_lut_ram #(
        .ADDR_WIDTH (MEM_WIDTH),
        .DATA_WIDTH (IP_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (beat),
        .wr_addr (wr_count[MEM_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Load FSM. All outputs are registered alongside the state.
    // A start in LOAD takes priority over the final beat: that beat is
    // still written, but the load restarts from address 0 with no done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ready  <= 1'b0;
            lut_ready <= 1'b0;
            done      <= 1'b0;
            wr_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        wr_ready <= 1'b1;
                        wr_count <= '0;
                    end
                end
                LOAD: begin
                    if (start) begin
                        wr_count <= '0;
                    end else if (beat) begin
                        wr_count <= wr_count + 1'b1;
                        if (last_beat) begin
                            state     <= READY;
                            wr_ready  <= 1'b0;
                            lut_ready <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (start) begin
                        state     <= LOAD;
                        wr_ready  <= 1'b1;
                        lut_ready <= 1'b0;
                        wr_count  <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wr_ready  <= 1'b0;
                    lut_ready <= 1'b0;
                    wr_count  <= '0;
                end
            endcase
        end
    end

endmodule
